// File: rtl/fmad_pkg.sv
// Shared definitions for the FMA-based op sequencer: command encoding,
// binary64 constants, exception flag layout and pipeline latency.
package fmad_pkg;

   typedef enum logic [2:0] {
      CMD_FMADD  = 3'd0,
      CMD_FMSUB  = 3'd1,
      CMD_FNMSUB = 3'd2,
      CMD_FNMADD = 3'd3,
      CMD_FADD   = 3'd4,
      CMD_FSUB   = 3'd5,
      CMD_FMUL   = 3'd6,
      CMD_RSVD   = 3'd7
   } cmd_e;

   localparam logic [63:0] FP_ONE      = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] FP_NEG_ZERO = 64'h8000_0000_0000_0000;

   localparam int FLAG_NV = 4;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;
   // Bit 3 has no meaning and is forced to zero on the way into the FIFO
   localparam logic [4:0] FLAG_MASK = 5'((1 << FLAG_NV) | (1 << FLAG_OF) |
                                         (1 << FLAG_UF) | (1 << FLAG_NX));

   localparam int FMA_LAT = 3;

   // Sign flip only; NaN payloads pass through untouched
   function automatic logic [63:0] fneg(input logic [63:0] v);
      return {~v[63], v[62:0]};
   endfunction

endpackage

// File: rtl/fmad_seq_fifo.sv
// In-order result FIFO with modulo-DEPTH pointers and an occupancy count.
// Storage is not reset; only pointers and count are.
module fmad_seq_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fmad_seq.sv
// Sequencer in front of a fixed-latency, non-stallable FMA pipeline.
// Credits guarantee FIFO space for every op in flight. Define
// FMAD_SEQ_FFLAGS_EN to get sticky fflags accumulation.
module fmad_seq
   import fmad_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int TAGW  = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_cmd,
   input  logic [63:0]     in_a,
   input  logic [63:0]     in_b,
   input  logic [63:0]     in_c,
   input  logic [TAGW-1:0] in_tag,
   output logic            fma_req,
   output logic [63:0]     fma_x,
   output logic [63:0]     fma_y,
   output logic [63:0]     fma_z,
   input  logic [63:0]     fma_rslt,
   input  logic [4:0]      fma_flag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [63:0]     out_data,
   output logic [4:0]      out_flag,
   output logic [TAGW-1:0] out_tag,
   output logic [4:0]      fflags,
   input  logic            fflags_clr
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(FMA_LAT + 1);
   localparam int EW = 64 + 5 + TAGW;

   logic                          accept, pop;
   logic [FMA_LAT:1]              vld_pipe;
   logic [FMA_LAT:1][TAGW-1:0]    tag_pipe;
   logic [IW-1:0]                 inflight;
   logic [CW-1:0]                 occ;
   logic                          fifo_full, fifo_empty;
   logic [EW-1:0]                 fifo_din, fifo_dout;

   // Credit check uses registered state only, so a same-cycle pop frees
   // its slot one cycle later
   assign inflight = IW'($countones(vld_pipe));
   assign in_ready = ~reset & ((int'(inflight) + int'(occ)) < DEPTH);
   assign accept   = in_valid & in_ready;
   assign fma_req  = accept;

   always_comb begin
      fma_x = in_a;
      fma_y = in_b;
      fma_z = in_c;
      case (cmd_e'(in_cmd))
         CMD_FMSUB:  fma_z = fneg(in_c);
         CMD_FNMSUB: fma_x = fneg(in_a);
         CMD_FNMADD: begin
            fma_x = fneg(in_a);
            fma_z = fneg(in_c);
         end
         CMD_FADD: begin
            fma_y = FP_ONE;
            fma_z = in_b;
         end
         CMD_FSUB: begin
            fma_y = FP_ONE;
            fma_z = fneg(in_b);
         end
         CMD_FMUL:   fma_z = FP_NEG_ZERO;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= {vld_pipe[FMA_LAT-1:1], accept};
   end

   always_ff @(posedge clk) begin
      tag_pipe <= {tag_pipe[FMA_LAT-1:1], in_tag};
   end

   assign fifo_din = {fma_rslt, fma_flag & FLAG_MASK, tag_pipe[FMA_LAT]};

   fmad_seq_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (vld_pipe[FMA_LAT]),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign out_data  = fifo_dout[EW-1 -: 64];
   assign out_flag  = fifo_dout[TAGW +: 5];
   assign out_tag   = fifo_dout[TAGW-1:0];

   a_no_write_full: assert property (@(posedge clk) disable iff (reset)
                                     !(vld_pipe[FMA_LAT] && fifo_full));

`ifdef FMAD_SEQ_FFLAGS_EN
   // Clear wins over accumulated history but not over the flag popped now
   always_ff @(posedge clk) begin
      if (reset)           fflags <= '0;
      else if (fflags_clr) fflags <= pop ? out_flag : '0;
      else if (pop)        fflags <= fflags | out_flag;
   end
`else
   logic unused_fflags_clr;
   assign unused_fflags_clr = fflags_clr;
   assign fflags = '0;
`endif

endmodule

// File: doc/fmad_seq.md
FMAD_SEQ -- requirements
Module: fmad_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning result-FIFO entries (minimum 2; 5 or more gives one accepted op per cycle).
REQ-002 SHALL have parameter TAGW, default 5, meaning tag width.
REQ-003 SHALL have ports `clk` (input, 1) for the clock and `reset` (input, 1) for a synchronous, active-high reset.
REQ-004 SHALL have ports `in_valid` (in, 1), `in_ready` (out, 1) and `in_cmd` (in, 3) for the op request handshake and command.
REQ-005 SHALL have ports `in_a`, `in_b`, `in_c` (in, 64 each) carrying IEEE binary64 operands.
REQ-006 SHALL have port `in_tag` (in, TAGW) carrying the requester tag.
REQ-007 SHALL have ports `fma_req` (out, 1) and `fma_x`, `fma_y`, `fma_z` (out, 64 each) driving the fused multiply-add pipeline.
REQ-008 SHALL have ports `fma_rslt` (in, 64) and `fma_flag` (in, 5) returning the pipeline result.
REQ-009 SHALL have ports `out_valid` (out, 1), `out_ready` (in, 1), `out_data` (out, 64), `out_flag` (out, 5) and `out_tag` (out, TAGW) for the result handshake.
REQ-010 SHALL have ports `fflags` (out, 5) for the sticky exception flags and `fflags_clr` (in, 1) to clear them.

Function
REQ-011 SHALL accept an op in a cycle where in_valid&in_ready, and drive fma_req=1 combinationally in that same cycle.
REQ-012 SHALL drive fma_req=0 in every other cycle.
REQ-013 SHALL map commands to x/y/z, where "-" means invert bit 63 (NaNs included):
- 0 FMADD: a, b, c
- 1 FMSUB: a, b, -c
- 2 FNMSUB: -a, b, c
- 3 FNMADD: -a, b, -c
- 4 FADD: a, 1.0, b
- 5 FSUB: a, 1.0, -b
- 6 FMUL: a, b, -0.0
- 7: treated as FMADD
REQ-014 SHALL use fixed pipeline latency 3: fma_rslt/fma_flag for an op accepted in cycle N are valid only in cycle N+3.
REQ-015 SHALL carry a 3-stage shift register of {valid, tag} and write {fma_rslt, fma_flag, tag} into the FIFO at the end of cycle N+3.
REQ-016 SHALL assert out_valid no earlier than cycle N+4.
REQ-017 SHALL keep the FIFO in order; results SHALL leave in acceptance order.
REQ-018 SHALL hold out_data, out_flag and out_tag stable while out_valid&~out_ready.
REQ-019 SHALL pop one entry when out_valid&out_ready.
REQ-020 SHALL use credit flow control: the pipeline cannot stall, so in_ready = ~reset & (inflight + occupancy < DEPTH).
REQ-021 SHALL compute in_ready from registered counts only; a pop in the same cycle does not raise in_ready until the next cycle.
REQ-022 SHALL handle a FIFO write and pop in the same cycle: occupancy unchanged, no data loss.
REQ-023 SHALL never write to a full FIFO (guaranteed by credits); an assertion SHALL check this.
REQ-024 SHALL wrap FIFO pointers modulo DEPTH.
REQ-025 SHALL keep the inflight count 0..3 and occupancy 0..DEPTH.

Reset
REQ-026 SHALL, on reset, clear inflight valids, pointers and counts, and set in_ready=0, out_valid=0, fma_req=0, fflags=0.
REQ-027 SHALL drop ops in flight when reset is asserted mid-operation; no result for them SHALL appear after reset.
REQ-028 SHALL reset only control state; FIFO data registers are not reset.

Configuration
REQ-029 SHALL, when macro FMAD_SEQ_FFLAGS_EN is defined, OR out_flag into fflags on each pop.
REQ-030 SHALL, when FMAD_SEQ_FFLAGS_EN is defined and fflags_clr=1, clear fflags; with simultaneous clr and pop, fflags becomes the popped out_flag.
REQ-031 SHALL, when FMAD_SEQ_FFLAGS_EN is undefined, tie fflags to 0, ignore fflags_clr and instantiate no register for fflags.
REQ-032 SHALL keep flag bit 3 always 0.

Structure
REQ-033 SHALL place the following in shared package fmad_pkg:
- command enum
- constants FP_ONE = 64'h3FF0_0000_0000_0000 and FP_NEG_ZERO = 64'h8000_0000_0000_0000
- flag bit indices: NV=4, OF=2, UF=1, NX=0
- FMA_LAT=3
REQ-034 SHALL implement the FIFO as one sub-module fmad_seq_fifo (parameterised depth/width, with push, pop, full, empty and count).

Verification
REQ-035 Bench SHALL cover: cmd 4, a=0x3FF0_0000_0000_0000, b=0x4000_0000_0000_0000 -> fma_y=0x3FF0_0000_0000_0000, fma_z=0x4000_0000_0000_0000, out_data=0x4008_0000_0000_0000 with out_valid in cycle N+4.
REQ-036 Bench SHALL cover: cmd 6, a=+0, b=-1.0 -> fma_z=0x8000_0000_0000_0000, out_data=0x8000_0000_0000_0000.
REQ-037 Bench SHALL cover: out_ready=0 with continuous in_valid -> exactly DEPTH ops accepted, in_ready=0 thereafter, no overflow; releasing out_ready drains tags in order.
REQ-038 Bench SHALL cover: with DEPTH=8 and out_ready=1, back-to-back in_valid -> one accept per cycle sustained and in_ready never deasserted.
REQ-039 Bench SHALL cover: reset pulsed with 3 ops in flight -> no out_valid for 5 cycles after reset, and counts are 0.
REQ-040 Bench SHALL cover, with FMAD_SEQ_FFLAGS_EN defined: pop with flag 5'h01, then pop with flag 5'h10 together with fflags_clr -> fflags 5'h01, then 5'h10; with the macro undefined, fflags stays 0.
